// File: rtl/servant_gpio_pkg.sv
// Shared definitions for the servant GPIO bank: register indices, the bus
// address type and the byte-enable expansion helper.
package servant_gpio_pkg;

    typedef logic [2:0] gpio_adr_t;

    localparam gpio_adr_t GPIO_OUT  = 3'd0;
    localparam gpio_adr_t GPIO_SET  = 3'd1;
    localparam gpio_adr_t GPIO_CLR  = 3'd2;
    localparam gpio_adr_t GPIO_TGL  = 3'd3;
    localparam gpio_adr_t GPIO_IN   = 3'd4;
    localparam gpio_adr_t GPIO_IREN = 3'd5;
    localparam gpio_adr_t GPIO_PEND = 3'd6;
    localparam gpio_adr_t GPIO_DIR  = 3'd7;

    // Expands the four Wishbone byte enables into a 32-bit bit mask.
    function automatic logic [31:0] sel_mask(input logic [3:0] sel);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = {8{sel[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/servant_sync.sv
// Multi-stage input synchroniser: each bit of d crosses STAGES flip-flops
// before appearing on q. Cleared to zero by the asynchronous reset.
module servant_sync #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/servant_gpio_bank.sv
// Wishbone GPIO bank: OUT with set/clear/toggle aliases, per-bit direction,
// synchronised inputs and a rising-edge interrupt with W1C pending bits.
module servant_gpio_bank
    import servant_gpio_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VAL   = '0,
    parameter logic [WIDTH-1:0] DIR_RESET   = '1,
    parameter int               SYNC_STAGES = 2
) (
    input  logic             wb_clk,
    input  logic             wb_rst,
    input  logic [2:0]       i_wb_adr,
    input  logic [31:0]      i_wb_dat,
    input  logic [3:0]       i_wb_sel,
    input  logic             i_wb_we,
    input  logic             i_wb_cyc,
    output logic [31:0]      o_wb_rdt,
    output logic             o_wb_ack,
    input  logic [WIDTH-1:0] i_gpio,
    output logic [WIDTH-1:0] o_q,
    output logic [WIDTH-1:0] o_oe,
    output logic             o_irq
);

    // Handshake: a request is taken on any edge with i_wb_cyc=1 and o_wb_ack=0;
    // that same edge performs the write, raises o_wb_ack for exactly one cycle
    // and loads o_wb_rdt with the pre-write value. o_wb_rdt is 0 outside ack.
    gpio_adr_t        adr;
    logic             accept;
    logic             wr;
    logic [31:0]      bmask32;
    logic [31:0]      wbits32;
    logic [WIDTH-1:0] wmask;
    logic [WIDTH-1:0] wbits;
    logic             unused_bits;

    logic [WIDTH-1:0] out_r, dir_r, iren_r, pend_r, prev_r;
    logic [WIDTH-1:0] out_nxt, dir_nxt, iren_nxt, pend_nxt, pend_clr;
    logic [WIDTH-1:0] in_sync, rise;
    logic [31:0]      rd_val;

    assign adr         = i_wb_adr;
    assign accept      = i_wb_cyc & ~o_wb_ack;
    assign wr          = accept & i_wb_we;
    assign bmask32     = sel_mask(i_wb_sel);
    assign wbits32     = i_wb_dat & bmask32;
    assign wmask       = bmask32[WIDTH-1:0];
    assign wbits       = wbits32[WIDTH-1:0];
    // Bits at WIDTH and above have nowhere to go; this only sinks them.
    assign unused_bits = ^{wbits32, bmask32};

    servant_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (wb_clk),
        .rst (wb_rst),
        .d   (i_gpio),
        .q   (in_sync)
    );

    assign rise = in_sync & ~prev_r;

    always_comb begin
        out_nxt  = out_r;
        dir_nxt  = dir_r;
        iren_nxt = iren_r;
        pend_clr = '0;
        if (wr) begin
            case (adr)
                GPIO_OUT:  out_nxt  = (out_r & ~wmask) | wbits;
                GPIO_SET:  out_nxt  = out_r | wbits;
                GPIO_CLR:  out_nxt  = out_r & ~wbits;
                GPIO_TGL:  out_nxt  = out_r ^ wbits;
                GPIO_IREN: iren_nxt = (iren_r & ~wmask) | wbits;
                GPIO_PEND: pend_clr = wbits;
                GPIO_DIR:  dir_nxt  = (dir_r & ~wmask) | wbits;
                default:   ;
            endcase
        end
        // A new edge outranks a simultaneous clear of the same bit.
        pend_nxt = (pend_r & ~pend_clr) | (rise & iren_r);
    end

    always_comb begin
        rd_val = '0;
        case (adr)
            GPIO_OUT, GPIO_SET, GPIO_CLR, GPIO_TGL: rd_val[WIDTH-1:0] = out_r;
            GPIO_IN:   rd_val[WIDTH-1:0] = in_sync;
            GPIO_IREN: rd_val[WIDTH-1:0] = iren_r;
            GPIO_PEND: rd_val[WIDTH-1:0] = pend_r;
            GPIO_DIR:  rd_val[WIDTH-1:0] = dir_r;
            default:   rd_val = '0;
        endcase
    end

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            out_r    <= RESET_VAL;
            dir_r    <= DIR_RESET;
            iren_r   <= '0;
            pend_r   <= '0;
            prev_r   <= '0;
            o_wb_ack <= 1'b0;
            o_wb_rdt <= '0;
        end else begin
            out_r    <= out_nxt;
            dir_r    <= dir_nxt;
            iren_r   <= iren_nxt;
            pend_r   <= pend_nxt;
            prev_r   <= in_sync;
            o_wb_ack <= accept;
            o_wb_rdt <= accept ? rd_val : 32'd0;
        end
    end

    assign o_q   = out_r;
    assign o_oe  = dir_r;
    assign o_irq = |pend_r;

endmodule

// File: tb/tb_servant_gpio_bank.sv
// Directed bench for servant_gpio_bank: bus read data goes through an
// expected queue checked by a monitor; pin and irq outputs are checked inline.
module tb_servant_gpio_bank;

    localparam int W = 8;

    logic          wb_clk;
    logic          wb_rst;
    logic [2:0]    i_wb_adr;
    logic [31:0]   i_wb_dat;
    logic [3:0]    i_wb_sel;
    logic          i_wb_we;
    logic          i_wb_cyc;
    logic [31:0]   o_wb_rdt;
    logic          o_wb_ack;
    logic [W-1:0]  i_gpio;
    logic [W-1:0]  o_q;
    logic [W-1:0]  o_oe;
    logic          o_irq;

    logic [31:0]   exp_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    logic          prev_ack = 1'b0;

    servant_gpio_bank #(
        .WIDTH       (W),
        .RESET_VAL   (8'hA5),
        .DIR_RESET   (8'hFF),
        .SYNC_STAGES (2)
    ) dut (
        .wb_clk   (wb_clk),
        .wb_rst   (wb_rst),
        .i_wb_adr (i_wb_adr),
        .i_wb_dat (i_wb_dat),
        .i_wb_sel (i_wb_sel),
        .i_wb_we  (i_wb_we),
        .i_wb_cyc (i_wb_cyc),
        .o_wb_rdt (o_wb_rdt),
        .o_wb_ack (o_wb_ack),
        .i_gpio   (i_gpio),
        .o_q      (o_q),
        .o_oe     (o_oe),
        .o_irq    (o_irq)
    );

    // Clock and reset
    initial wb_clk = 1'b0;
    always #5 wb_clk = ~wb_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Driver tasks: called #1 after a rising edge (or at release of reset).
    task automatic idle(input int n);
        repeat (n) @(posedge wb_clk);
        #1;
    endtask

    task automatic bus(input logic [2:0] adr, input logic we, input logic [31:0] dat,
                       input logic [3:0] sel, input logic [31:0] exp_rdt);
        exp_q.push_back(exp_rdt);
        i_wb_adr = adr;
        i_wb_we  = we;
        i_wb_dat = dat;
        i_wb_sel = sel;
        i_wb_cyc = 1'b1;
        @(posedge wb_clk);
        #1;
        check("ack_rise", {31'd0, o_wb_ack}, 32'd1);
        i_wb_cyc = 1'b0;
        i_wb_we  = 1'b0;
        @(posedge wb_clk);
        #1;
        check("ack_fall", {31'd0, o_wb_ack}, 32'd0);
    endtask

    // Scoreboard monitor
    always @(negedge wb_clk) begin
        if (!wb_rst) begin
            if (o_wb_ack) begin
                if (prev_ack) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL ack_back_to_back: got 1 expected 0 at %0t", $time);
                end
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rdt_unexpected: got ack with rdt %h expected no ack", o_wb_rdt);
                end else begin
                    check("rdt", o_wb_rdt, exp_q.pop_front());
                end
            end else begin
                check("rdt_idle_zero", o_wb_rdt, 32'd0);
            end
        end
        prev_ack <= o_wb_ack;
    end

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        wb_rst   = 1'b1;
        i_wb_adr = '0;
        i_wb_dat = '0;
        i_wb_sel = '0;
        i_wb_we  = 1'b0;
        i_wb_cyc = 1'b0;
        i_gpio   = '0;
        #1;
        check("rst_q",   {24'd0, o_q},  32'h0000_00A5);
        check("rst_oe",  {24'd0, o_oe}, 32'h0000_00FF);
        check("rst_irq", {31'd0, o_irq}, 32'd0);
        check("rst_ack", {31'd0, o_wb_ack}, 32'd0);
        idle(3);
        wb_rst = 1'b0;

        // Read reset value, then OUT aliases
        bus(3'd0, 1'b0, 32'h0,         4'hF,    32'h0000_00A5);
        bus(3'd0, 1'b1, 32'hFFFF_FF0F, 4'b0001, 32'h0000_00A5);
        check("q_out", {24'd0, o_q}, 32'h0F);
        bus(3'd1, 1'b1, 32'h30, 4'hF, 32'h0F);
        check("q_set", {24'd0, o_q}, 32'h3F);
        bus(3'd2, 1'b1, 32'h01, 4'hF, 32'h3F);
        check("q_clr", {24'd0, o_q}, 32'h3E);
        bus(3'd3, 1'b1, 32'h81, 4'hF, 32'h3E);
        check("q_tgl", {24'd0, o_q}, 32'hBF);
        bus(3'd0, 1'b0, 32'h0, 4'hF, 32'hBF);
        bus(3'd0, 1'b1, 32'h0, 4'b0010, 32'hBF);
        check("q_sel_masked", {24'd0, o_q}, 32'hBF);
        bus(3'd1, 1'b0, 32'h0, 4'hF, 32'hBF);

        // Rising-edge interrupt on enabled bit 2
        bus(3'd5, 1'b1, 32'h04, 4'hF, 32'h00);
        i_gpio = 8'h04;
        idle(2);
        check("irq_before", {31'd0, o_irq}, 32'd0);
        idle(1);
        check("irq_after", {31'd0, o_irq}, 32'd1);
        bus(3'd4, 1'b0, 32'h0, 4'hF, 32'h04);
        i_gpio = 8'h0C;
        idle(4);
        bus(3'd6, 1'b0, 32'h0, 4'hF, 32'h04);
        bus(3'd4, 1'b0, 32'h0, 4'hF, 32'h0C);

        // Edge on bit 2 coinciding with its W1C
        i_gpio = 8'h08;
        idle(4);
        i_gpio = 8'h0C;
        idle(2);
        bus(3'd6, 1'b1, 32'h04, 4'hF, 32'h04);
        check("irq_set_wins", {31'd0, o_irq}, 32'd1);
        bus(3'd6, 1'b0, 32'h0, 4'hF, 32'h04);
        bus(3'd6, 1'b1, 32'h04, 4'hF, 32'h04);
        check("irq_cleared", {31'd0, o_irq}, 32'd0);
        bus(3'd6, 1'b0, 32'h0, 4'hF, 32'h00);

        // Back-to-back reads with cyc held
        exp_q.push_back(32'hFF);
        exp_q.push_back(32'hFF);
        i_wb_adr = 3'd7;
        i_wb_we  = 1'b0;
        i_wb_cyc = 1'b1;
        idle(1); check("b2b_ack0", {31'd0, o_wb_ack}, 32'd1);
        idle(1); check("b2b_ack1", {31'd0, o_wb_ack}, 32'd0);
        idle(1); check("b2b_ack2", {31'd0, o_wb_ack}, 32'd1);
        idle(1); check("b2b_ack3", {31'd0, o_wb_ack}, 32'd0);
        i_wb_cyc = 1'b0;
        idle(1);

        // Reset during an ack cycle
        i_wb_adr = 3'd0;
        i_wb_we  = 1'b1;
        i_wb_dat = 32'h0;
        i_wb_sel = 4'b0001;
        i_wb_cyc = 1'b1;
        idle(1);
        check("mid_ack", {31'd0, o_wb_ack}, 32'd1);
        check("mid_q",   {24'd0, o_q}, 32'h00);
        wb_rst   = 1'b1;
        i_wb_cyc = 1'b0;
        i_wb_we  = 1'b0;
        #1;
        check("mid_rst_ack", {31'd0, o_wb_ack}, 32'd0);
        check("mid_rst_rdt", o_wb_rdt, 32'd0);
        check("mid_rst_q",   {24'd0, o_q},  32'hA5);
        check("mid_rst_oe",  {24'd0, o_oe}, 32'hFF);
        idle(2);
        wb_rst = 1'b0;
        idle(4);
        check("post_rst_irq", {31'd0, o_irq}, 32'd0);

        // DIR write and ignored IN write
        bus(3'd7, 1'b1, 32'h0F, 4'b0001, 32'hFF);
        check("oe_dir", {24'd0, o_oe}, 32'h0F);
        check("q_dir",  {24'd0, o_q},  32'hA5);
        bus(3'd4, 1'b1, 32'hFF, 4'hF, 32'h0C);
        bus(3'd0, 1'b0, 32'h0, 4'hF, 32'hA5);
        bus(3'd7, 1'b0, 32'h0, 4'hF, 32'h0F);
        bus(3'd5, 1'b0, 32'h0, 4'hF, 32'h00);
        bus(3'd6, 1'b0, 32'h0, 4'hF, 32'h00);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/servant_gpio_bank.md
# servant_gpio_bank

Parametrised Wishbone GPIO bank for the servant SoC, replacing the single-bit `q` output with a `WIDTH`-bit port. It provides atomic set/clear/toggle, per-bit output enable, synchronised inputs, and a rising-edge interrupt. It sits on the servant data bus next to the timer and drives the board pins from the SoC top level.

## Interface
- `WIDTH`, 8, number of GPIO bits (1..32).
- `RESET_VAL`, 0, reset value of the OUT register.
- `DIR_RESET`, all ones, reset value of the DIR register (1 = pin driven).
- `SYNC_STAGES`, 2, flip-flops in each input synchroniser (2..4).
- `wb_clk`  in  1  system clock; the only clock.
- `wb_rst`  in  1  reset; asynchronous, active-high.
- `i_wb_adr`  in  3  word address; byte address bits [4:2].
- `i_wb_dat`  in  32  write data.
- `i_wb_sel`  in  4  byte enables.
- `i_wb_we`  in  1  write strobe.
- `i_wb_cyc`  in  1  bus cycle valid; no separate stb.
- `o_wb_rdt`  out  32  read data; valid while `o_wb_ack` is high.
- `o_wb_ack`  out  1  single-cycle acknowledge.
- `i_gpio`  in  WIDTH  asynchronous pin inputs.
- `o_q`  out  WIDTH  pin output values.
- `o_oe`  out  WIDTH  pin output enables.
- `o_irq`  out  1  level interrupt; OR of the IRQ_PEND bits.

## Operation
Register map (word index):
- 0 OUT: read/write; honours `i_wb_sel`.
- 1 SET: write-1-to-set OUT bits; reads return OUT.
- 2 CLR: write-1-to-clear OUT bits; reads return OUT.
- 3 TGL: write-1-to-toggle OUT bits; reads return OUT.
- 4 IN: read-only synchronised input value; writes are ignored.
- 5 IRQ_EN: read/write; honours `i_wb_sel`.
- 6 IRQ_PEND: write-1-to-clear; reads return the pending bits.
- 7 DIR: read/write; honours `i_wb_sel`; drives `o_oe`.

Bit and byte rules:
- `i_wb_sel` masks every write at byte granularity. SET/CLR/TGL/PEND bits outside the enabled bytes are unaffected.
- Bits at position `WIDTH` and above read as 0; writes to them are discarded.
- `o_q` = OUT and `o_oe` = DIR, driven directly from the registers.

Inputs and interrupts:
- Each `i_gpio` bit passes through a `SYNC_STAGES` flip-flop chain; IN is the last stage.
- A per-bit previous-value register follows IN.
- A rising edge is IN=1 while previous=0. It sets IRQ_PEND[i] when IRQ_EN[i] is 1.
- Clearing IRQ_EN does not clear bits that are already pending.

Simultaneous events:
- An edge and a W1C of the same PEND bit in the same cycle: set wins, the bit stays 1.
- A TGL write with its mask is an ordinary read-modify-write of OUT; there is no conflicting update path.

## Timing
- A request is accepted at the rising edge where `i_wb_cyc`=1 and `o_wb_ack`=0 (edge N).
- At edge N:
  - the register write takes effect;
  - `o_wb_ack` goes to 1;
  - `o_wb_rdt` is loaded with the pre-write register value.
- At edge N+1 `o_wb_ack` returns to 0. The fixed latency is one cycle, and `o_wb_ack` is never high on two consecutive cycles.
- The master drops `i_wb_cyc` in the ack cycle. If it holds `i_wb_cyc`, a new access is accepted at edge N+2.
- `o_wb_rdt` is 0 whenever `o_wb_ack` is 0.
- Input latency: an `i_gpio` change appears in IN `SYNC_STAGES` edges later. The resulting `o_irq` asserts one edge after that.
- `o_q`/`o_oe` change at edge N of the write; `o_irq` drops at edge N of the clearing write.

Reset values (applied asynchronously while `wb_rst`=1, with outputs settling immediately):
- OUT = RESET_VAL, DIR = DIR_RESET.
- IRQ_EN = 0, IRQ_PEND = 0.
- Synchronisers and previous-value register = 0.
- `o_wb_ack` = 0, `o_wb_rdt` = 0, `o_irq` = 0.

Reset mid-access drops any in-flight ack with no write side effect beyond the reset values. After reset release, an input already high produces a rising edge, but it raises an interrupt only if IRQ_EN has been set by then.

## Structure
- Package `servant_gpio_pkg` holds:
  - the register index localparams (`GPIO_OUT` .. `GPIO_DIR`);
  - the 3-bit address type;
  - the byte-mask expansion function (sel to 32-bit mask).
- One sub-module, `servant_sync`: a parametrised `SYNC_STAGES` x `WIDTH` synchroniser with async reset to 0.
- The bus decoder, register file and edge/interrupt logic live in `servant_gpio_bank`.

## Test plan
- Reset with WIDTH=8, RESET_VAL=8'hA5 -> `o_q`=A5, `o_oe`=FF, `o_irq`=0, `o_wb_ack`=0. Read word 0 -> `o_wb_rdt`=0000_00A5, ack exactly one cycle after cyc.
- Write OUT=FFFF_FF0F with sel=4'b0001, then SET 0x30, CLR 0x01, TGL 0x81 -> `o_q` goes 0F, 3F, 3E, BF. Read returns 0000_00BF; bits [31:8] are always 0.
- IRQ_EN=0x04; drive `i_gpio[2]` 0->1 -> IN reads 0x04 after 2 cycles and `o_irq`=1 one cycle later. A rising edge on bit 3 (disabled) leaves PEND=0x04.
- Edge on bit 2 in the same cycle as a W1C 0x04 to PEND -> PEND stays 0x04 and `o_irq` stays 1. A later W1C with no edge -> PEND=0, `o_irq`=0.
- Hold `i_wb_cyc` high for four cycles of reads -> ack pattern 1,0,1,0. Assert `wb_rst` in an ack cycle -> ack drops immediately and registers return to their reset values.
- DIR write 0x0F -> `o_oe`=0F with `o_q` unchanged. Write to IN -> no register changes; ack is still returned.
